nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit adder that streams operands through a single 4-bit carry-lookahead cell, one nibble per clock, least-significant first. It sits directly upstream of the `four_bit_cla` cell: it sequences operand nibbles and carry into the cell and collects its sum nibbles and carry-out. Valid/ready handshakes on both sides let it drop into datapaths that cannot afford a full-width adder.

## Interface
Parameters:
- `WIDTH`, default 16: operand width. Must be a multiple of 4 and at least 4; elaboration error otherwise.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Reset, synchronous and active-low.
- `in_valid`: input, 1 bit. Operands `a`, `b` and `cin` are valid.
- `in_ready`: output, 1 bit. Block is idle and accepts operands.
- `a`: input, WIDTH bits. Operand A.
- `b`: input, WIDTH bits. Operand B.
- `cin`: input, 1 bit. Carry-in.
- `out_valid`: output, 1 bit. Result is valid and held.
- `out_ready`: input, 1 bit. Consumer accepts the result.
- `sum`: output, WIDTH bits. A + B + cin, modulo 2^WIDTH.
- `cout`: output, 1 bit. Unsigned carry-out.
- `overflow`: output, 1 bit. Two's-complement overflow.

## Operation
- N = WIDTH/4 nibbles. FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready` = 1 (forced 0 while `rst_n` = 0).
  - On `in_valid && in_ready`:
    - latch `a` and `b` into shift registers;
    - `carry` <= `cin`;
    - `idx` <= 0;
    - record the operand MSBs `a[WIDTH-1]` and `b[WIDTH-1]`;
    - go to RUN.
- **RUN**, each cycle:
  - the CLA cell adds the low nibbles of the A and B shift registers plus `carry`;
  - its sum nibble is written to `sum_reg[4*idx +: 4]`;
  - `carry` <= the cell's C4;
  - both operand shift registers shift right by 4;
  - `idx` increments.
  - When `idx` = N-1: go to DONE.
- **DONE**
  - `out_valid` = 1.
  - `sum` = `sum_reg`, `cout` = `carry`.
  - `overflow` = (a_msb == b_msb) && (sum_reg[WIDTH-1] != a_msb).
  - On `out_valid && out_ready`: go to IDLE.
- **Held values**
  - `sum`, `cout` and `overflow` are registered.
  - They hold their last value outside DONE.
  - They are stable for the whole of DONE.
- **Inputs ignored**
  - `in_valid` is ignored in RUN and DONE.
  - `out_ready` is ignored outside DONE.
- No overlap: a new operation is accepted only from IDLE.

## Timing
- **Reset values** (on any edge with `rst_n` = 0, in any state, including mid-RUN):
  - state IDLE, `idx` 0, `carry` 0;
  - `sum` 0, `cout` 0, `overflow` 0, `out_valid` 0;
  - `in_ready` = 1 from the first cycle after `rst_n` returns high.
  - A partial result is discarded and never presented.
- **Latency:** operands accepted at edge k give `out_valid` = 1 after edge k+N (4 cycles for WIDTH = 16).
- **Throughput:**
  - result accepted at edge m puts the block in IDLE;
  - the next accept is at edge m+1 at the earliest;
  - minimum period is N+2 cycles per operation.
- **Backpressure:** DONE is held indefinitely while `out_ready` = 0; outputs do not change.
- **Simultaneous events:** `in_valid` asserted in the same cycle as the output handshake is not accepted; it is taken the following cycle.
- **Width rules:**
  - `idx` is ceil(log2(N)) bits, minimum 1.
  - The sum is modulo 2^WIDTH.
  - `cout` is the carry out of nibble N-1.

## Structure
- **Shared package / include `adder_pkg`:**
  - `NIBBLE` = 4;
  - state encoding localparams `ST_IDLE`, `ST_RUN`, `ST_DONE` (2-bit);
  - the WIDTH legality check macro.
- **One sub-module:** a single instance of `four_bit_cla` as the nibble adder cell.
  - Inputs: operand low nibbles and `carry`.
  - Outputs: sum nibble and C4.
  - No other arithmetic in this block.
- **Top holds:** FSM, `idx` counter, operand shift registers, `sum_reg`, `carry` register, MSB capture.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 -> `out_valid` exactly 4 cycles after accept; `sum`=0x5555, `cout`=0, `overflow`=0.
- a=0xFFFF, b=0x0001, cin=0 -> `sum`=0x0000, `cout`=1, `overflow`=0 (carry ripples through all 4 nibbles); a=0x7FFF, b=0x0001 -> `sum`=0x8000, `cout`=0, `overflow`=1.
- a=0x00FF, b=0x0F00, cin=1 -> `sum`=0x1000, `cout`=0; a=0x8000, b=0x8000, cin=0 -> `sum`=0x0000, `cout`=1, `overflow`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE with `in_valid`=1 and new operands -> outputs stable, `in_ready`=0, the new operands are not taken; after the handshake, the next operation is accepted one cycle later and is correct.
- Reset mid-op: drive `rst_n`=0 for one edge during the 2nd RUN cycle -> `out_valid`=0, `sum`=0, `cout`=0 next cycle, `in_ready`=1 after release; a following 0x0001+0x0001 gives 0x0002.
- Back-to-back random regression (1000 ops, random `out_ready` stalls, WIDTH=16 and WIDTH=4) -> every result matches the {`cout`, `sum`} reference model; no result is lost or duplicated.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble size, FSM encoding, WIDTH legality.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

    localparam int NIBBLE = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Operand width must be a whole number of nibbles, at least one.
    function automatic bit width_ok(input int w);
        return (w >= NIBBLE) && ((w % NIBBLE) == 0);
    endfunction

endpackage

// File: rtl/four_bit_cla.sv
// 4-bit carry-lookahead adder cell: s = a + b + c0, c4 = carry out of bit 3.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
// Ports: a, b (4-bit operands), c0 (carry in), s (4-bit sum), c4 (carry out).
module four_bit_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p/c0, no ripple chain.
    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);

    assign s = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams operands through one 4-bit CLA cell, LS nibble first.
// Latency: accept at edge k gives out_valid after edge k+N (N = WIDTH/4); period N+2 minimum.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no overlap.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with a, b, cin;
//        out_valid/out_ready with registered sum, cout, overflow.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / NIBBLE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if (!width_ok(WIDTH)) begin : g_width_chk
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic [3:0]       cla_s;
    logic             cla_c4;
    logic             accept;
    logic             last;

    four_bit_cla u_cla (
        .a  (a_sh[NIBBLE-1:0]),
        .b  (b_sh[NIBBLE-1:0]),
        .c0 (carry),
        .s  (cla_s),
        .c4 (cla_c4)
    );

    // in_ready is gated by rst_n so nothing is accepted on a reset edge.
    assign in_ready  = (state == S_IDLE) && rst_n;
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (idx == IDX_W'(N - 1));

    // sum_reg with the current nibble slot replaced by the cell's output.
    always_comb begin
        sum_nxt = sum_reg;
        sum_nxt[int'(idx) * NIBBLE +: NIBBLE] = cla_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid)  state_nxt = S_RUN;
            S_RUN:  if (last)      state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_reg  <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            idx   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == S_RUN) begin
            sum_reg <= sum_nxt;
            carry   <= cla_c4;
            a_sh    <= a_sh >> NIBBLE;
            b_sh    <= b_sh >> NIBBLE;
            idx     <= idx + IDX_W'(1);
            // Outputs load only as the last nibble completes, so they never
            // show a partial result and hold through DONE and the next RUN.
            if (last) begin
                sum      <= sum_nxt;
                cout     <= cla_c4;
                overflow <= (a_msb == b_msb) && (sum_nxt[WIDTH-1] != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int NOPS = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid16 = 1'b0, in_ready16, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        out_valid16, out_ready16 = 1'b0, cout16, overflow16;

    logic        in_valid4 = 1'b0, in_ready4, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0, sum4;
    logic        out_valid4, out_ready4 = 1'b0, cout4, overflow4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .overflow(overflow16)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .overflow(overflow4)
    );

    // Reference: plain integer arithmetic. Returns {overflow, cout, sum[15:0]}.
    function automatic logic [17:0] ref_model(input int w, input int x, input int y, input int c);
        int full = 1 << w;
        int half = 1 << (w - 1);
        int u, sx, sy, sv;
        logic [17:0] r;
        u  = x + y + c;
        sx = (x >= half) ? x - full : x;
        sy = (y >= half) ? y - full : y;
        sv = sx + sy + c;
        r[15:0] = 16'(u % full);
        r[16]   = (u >= full);
        r[17]   = (sv >= half) || (sv < -half);
        return r;
    endfunction

    // Present operands, wait for accept, then count edges until out_valid.
    // Called and returns at #1 after a rising edge.
    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        output int lat, output logic timed_out);
        int n = 0;
        timed_out = 1'b0;
        a16 = av; b16 = bv; cin16 = ci; in_valid16 = 1'b1;
        while (!in_ready16 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid16 || n >= 50) timed_out = 1'b1;
    endtask

    task automatic take16();
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid16); end
        checks++; if (sum16 !== 16'h0) begin errors++; $display("FAIL reset_sum got %h exp 0000", sum16); end
        checks++; if ({cout16, overflow16} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf got %b exp 00", {cout16, overflow16}); end
        checks++; if (in_ready16 !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got %b exp 0", in_ready16); end
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid4 got %b exp 0", out_valid4); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready16 !== 1'b1 || in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_release got %b%b exp 11", in_ready16, in_ready4); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [15:0] ta[5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h00FF, 16'h8000};
        logic [15:0] tb[5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0F00, 16'h8000};
        logic        tc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] es[5] = '{16'h5555, 16'h0000, 16'h8000, 16'h1000, 16'h0000};
        logic        ec[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        eo[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat;
        logic to;
        for (int i = 0; i < 5; i++) begin
            op16(ta[i], tb[i], tc[i], lat, to);
            checks++; if (to) begin errors++; $display("FAIL dir%0d_timeout got no out_valid exp out_valid", i); end
            checks++; if (lat != 4) begin errors++; $display("FAIL dir%0d_latency got %0d exp 4", i, lat); end
            checks++; if (sum16 !== es[i]) begin errors++; $display("FAIL dir%0d_sum got %h exp %h", i, sum16, es[i]); end
            checks++; if (cout16 !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got %b exp %b", i, cout16, ec[i]); end
            checks++; if (overflow16 !== eo[i]) begin errors++; $display("FAIL dir%0d_overflow got %b exp %b", i, overflow16, eo[i]); end
            take16();
        end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        logic to;
        op16(16'h1234, 16'h1111, 1'b0, lat, to);
        checks++; if (to || sum16 !== 16'h2345) begin errors++; $display("FAIL bp_first got %h to=%b exp 2345", sum16, to); end
        a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b0; in_valid16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid16 !== 1'b1 || sum16 !== 16'h2345 || in_ready16 !== 1'b0 || cout16 !== 1'b0 || overflow16 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b s=%h r=%b exp v=1 s=2345 r=0", i, out_valid16, sum16, in_ready16);
            end
        end
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        checks++; if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin errors++; $display("FAIL bp_same_cycle got v=%b r=%b exp v=0 r=1", out_valid16, in_ready16); end
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        checks++; if (in_ready16 !== 1'b0) begin errors++; $display("FAIL bp_next_accept got in_ready %b exp 0", in_ready16); end
        lat = 0;
        while (!out_valid16 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat != 4) begin errors++; $display("FAIL bp_second_latency got %0d exp 4", lat); end
        checks++; if ({overflow16, cout16, sum16} !== {1'b0, 1'b0, 16'hFFFF}) begin errors++; $display("FAIL bp_second_result got %b %b %h exp 0 0 ffff", overflow16, cout16, sum16); end
        take16();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic to;
        logic seen = 1'b0;
        a16 = 16'h0F0F; b16 = 16'h0101; cin16 = 1'b1; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid16 !== 1'b0 || sum16 !== 16'h0 || cout16 !== 1'b0) begin errors++; $display("FAIL rstmid_clear got v=%b s=%h c=%b exp 0 0000 0", out_valid16, sum16, cout16); end
        checks++; if (in_ready16 !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready_low got %b exp 0", in_ready16); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready16 !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", in_ready16); end
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid16 !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rstmid_partial got out_valid 1 exp 0"); end
        op16(16'h0001, 16'h0001, 1'b0, lat, to);
        checks++; if (to || lat != 4 || sum16 !== 16'h0002 || cout16 !== 1'b0) begin errors++; $display("FAIL rstmid_after got s=%h lat=%0d exp 0002 lat 4", sum16, lat); end
        take16();
    endtask

    task automatic test_back_to_back();
        logic [17:0] q16[$];
        logic [17:0] q4[$];
        logic [17:0] exp;
        int got16 = 0, got4 = 0, sent16 = 0, sent4 = 0, cyc = 0;
        logic acc16, acc4;
        while ((got16 < NOPS || got4 < NOPS) && cyc < 40000) begin
            out_ready16 = ($urandom_range(0, 2) != 0);
            out_ready4  = ($urandom_range(0, 2) != 0);
            if (out_valid16 && out_ready16) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++; $display("FAIL rand16_extra got result %h exp none", sum16);
                end else begin
                    exp = q16.pop_front();
                    if ({overflow16, cout16, sum16} !== exp) begin
                        errors++; $display("FAIL rand16_result got %h exp %h", {overflow16, cout16, sum16}, exp);
                    end
                end
                got16++;
            end
            if (out_valid4 && out_ready4) begin
                checks++;
                if (q4.size() == 0) begin
                    errors++; $display("FAIL rand4_extra got result %h exp none", sum4);
                end else begin
                    exp = q4.pop_front();
                    if ({overflow4, cout4, 12'h000, sum4} !== exp) begin
                        errors++; $display("FAIL rand4_result got %b %b %h exp %h", overflow4, cout4, sum4, exp);
                    end
                end
                got4++;
            end
            if (!in_valid16 && sent16 < NOPS && $urandom_range(0, 3) != 0) begin
                a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); in_valid16 = 1'b1;
            end
            if (!in_valid4 && sent4 < NOPS && $urandom_range(0, 3) != 0) begin
                a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); in_valid4 = 1'b1;
            end
            acc16 = in_valid16 && in_ready16;
            acc4  = in_valid4 && in_ready4;
            if (acc16) begin q16.push_back(ref_model(16, int'(a16), int'(b16), int'(cin16))); sent16++; end
            if (acc4)  begin q4.push_back(ref_model(4, int'(a4), int'(b4), int'(cin4))); sent4++; end
            @(posedge clk); #1;
            if (acc16) in_valid16 = 1'b0;
            if (acc4)  in_valid4 = 1'b0;
            cyc++;
        end
        out_ready16 = 1'b0;
        out_ready4  = 1'b0;
        checks++; if (got16 != NOPS || q16.size() != 0) begin errors++; $display("FAIL rand16_count got %0d left %0d exp %0d left 0", got16, q16.size(), NOPS); end
        checks++; if (got4 != NOPS || q4.size() != 0) begin errors++; $display("FAIL rand4_count got %0d left %0d exp %0d left 0", got4, q4.size(), NOPS); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
